uart_tx_engine: RTL and testbench

//  Serial UART transmitter: the transmit-side counterpart of the UART receiver.

---
 rtl/uart_tx_engine.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter: valid/ready byte input, start + 8 data bits (LSB first) +
// optional parity + 1 or 2 stop bits on a registered, idle-high tx line.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_valid,
  input  logic [3:0] c_addr,
  input  logic [7:0] c_data,
  output logic       c_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [3:0] ADDR_PARITY = 4'b0101;
  localparam logic [3:0] ADDR_STOP   = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            par, par_n;
  logic            tx_q, tx_n;
  logic [1:0]      parity_mode, parity_mode_n;
  logic            stop2, stop2_n;

  logic            bit_end;
  logic            parity_on;
  logic            cfg_we;
  logic            cfg_unused;

  assign c_ready    = (state == S_IDLE);
  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign tx         = tx_q;
  assign cfg_we     = c_valid && c_ready;
  assign bit_end    = (cnt == LAST);
  assign parity_on  = parity_mode[0] ^ parity_mode[1];
  assign cfg_unused = ^c_data[7:2];

  // Config only changes in IDLE, so the registered values are frozen for the
  // whole frame; a write in the accept cycle lands before the first bit needs it.
  assign tx_done = (state == S_STOP) && bit_end && (!stop2 || idx[0]);

  // NOTE: every *_n signal takes its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n       = state;
    cnt_n         = bit_end ? '0 : cnt + 1'b1;
    idx_n         = idx;
    shreg_n       = shreg;
    par_n         = par;
    tx_n          = tx_q;
    parity_mode_n = parity_mode;
    stop2_n       = stop2;

    if (cfg_we) begin
      if (c_addr == ADDR_PARITY) parity_mode_n = c_data[1:0];
      if (c_addr == ADDR_STOP)   stop2_n       = c_data[0];
    end

    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        tx_n  = 1'b1;
        if (in_valid) begin
          state_n = S_START;
          shreg_n = in_data;
          par_n   = ^in_data;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          idx_n   = '0;
          tx_n    = shreg[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_n = {1'b0, shreg[7:1]};
          if (idx == 3'd7) begin
            idx_n = '0;
            if (parity_on) begin
              state_n = S_PARITY;
              tx_n    = par ^ parity_mode[1];
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx + 1'b1;
            tx_n  = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          idx_n   = '0;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          if (stop2 && !idx[0]) begin
            idx_n = 3'd1;
          end else begin
            state_n = S_IDLE;
            idx_n   = '0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous and covers every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tx_q        <= 1'b1;
      parity_mode <= 2'b00;
      stop2       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      par         <= par_n;
      tx_q        <= tx_n;
      parity_mode <= parity_mode_n;
      stop2       <= stop2_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a scoreboard of sent bytes and their
// frame config is replayed against a cycle-accurate decode of tx/tx_done/busy.
module tb_uart_tx_engine;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       c_valid;
  logic [3:0] c_addr;
  logic [7:0] c_data;
  logic       c_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .c_valid  (c_valid),
    .c_addr   (c_addr),
    .c_data   (c_data),
    .c_ready  (c_ready),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       s2;
    int         n;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] cfg_pm;
  logic       cfg_s2;
  int         n_checks = 0;
  int         n_pass   = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [7:0] d, input int n);
    sb.push_back('{data: d, pm: cfg_pm, s2: cfg_s2, n: n});
  endtask

  // Returns the cycle in which in_ready is seen high (accept cycle), or -1.
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 0; i < 1000; i++) begin
      if (in_ready === 1'b1) begin
        n = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_c_ready(output int n);
    n = -1;
    for (int i = 0; i < 1000; i++) begin
      if (c_ready === 1'b1) begin
        n = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    c_valid = 1'b1;
    c_addr  = a;
    c_data  = d;
    wait_c_ready(n);
    n_checks++;
    if (n < 0) $display("FAIL cfg_write_timeout: c_ready never 1, required 1");
    else n_pass++;
    if (a == 4'b0101) cfg_pm = d[1:0];
    if (a == 4'b0110) cfg_s2 = d[0];
    @(negedge clk);
    c_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output int n);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    wait_ready(n);
    n_checks++;
    if (n < 0) $display("FAIL send_timeout: in_ready never 1, required 1");
    else begin
      n_pass++;
      push_exp(d, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Decodes one frame cycle by cycle against the oldest scoreboard entry.
  task automatic recv_frame();
    exp_t        e;
    int          s, nb, len, t;
    logic [11:0] bits;
    logic        bit_ok, done_ok, busy_ok, seen, found;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      $display("FAIL frame_start_timeout: tx stayed %b, required 0", tx);
      return;
    end
    if (sb.size() == 0) begin
      $display("FAIL frame_unexpected: got a start bit at cycle %0d, required no frame", cyc);
      return;
    end
    n_pass++;
    e = sb.pop_front();
    s = cyc;
    n_checks++;
    if (s !== e.n + 1) $display("FAIL start_latency byte %h: tx fell at %0d, required %0d", e.data, s, e.n + 1);
    else n_pass++;

    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = e.data;
    nb = 9;
    if (e.pm == 2'b01 || e.pm == 2'b10) begin
      bits[9] = (e.pm == 2'b10) ? ~^e.data : ^e.data;
      nb = 10;
    end
    nb  = nb + (e.s2 ? 2 : 1);
    len = nb * CPB;
    done_ok = 1'b1;
    busy_ok = 1'b1;
    for (int b = 0; b < nb; b++) begin
      bit_ok = 1'b1;
      seen   = bits[b];
      for (int k = 0; k < CPB; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        t = b * CPB + k;
        if (tx !== bits[b]) begin
          bit_ok = 1'b0;
          seen   = tx;
        end
        if (tx_done !== (t == len - 1)) done_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
      n_checks++;
      if (!bit_ok) $display("FAIL tx_bit%0d byte %h pm %0d: saw %b, required %b for %0d clk", b, e.data, e.pm, seen, bits[b], CPB);
      else n_pass++;
    end
    n_checks++;
    if (!done_ok) $display("FAIL tx_done byte %h: pulse not only at cycle %0d, required single pulse there", e.data, e.n + len);
    else n_pass++;
    n_checks++;
    if (!busy_ok) $display("FAIL busy byte %h: busy dropped during frame, required 1", e.data);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({tx, busy, in_ready} !== 3'b101)
      $display("FAIL post_frame_idle byte %h: tx/busy/in_ready=%b, required 101", e.data, {tx, busy, in_ready});
    else n_pass++;
  endtask

  task automatic send_and_check(input logic [7:0] d);
    int n;
    fork
      send_byte(d, n);
      recv_frame();
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    c_valid = 1'b0; c_addr = '0; c_data = '0;
    in_valid = 1'b0; in_data = '0;
    cfg_pm = 2'b00; cfg_s2 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx, busy, tx_done, in_ready, c_ready} !== 5'b10011)
      $display("FAIL reset_in: tx/busy/done/in_ready/c_ready=%b, required 10011", {tx, busy, tx_done, in_ready, c_ready});
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx, busy, tx_done, in_ready, c_ready} !== 5'b10011)
      $display("FAIL reset_out: tx/busy/done/in_ready/c_ready=%b, required 10011", {tx, busy, tx_done, in_ready, c_ready});
    else n_pass++;
  endtask

  task automatic test_default();
    send_and_check(8'hA7);
  endtask

  task automatic test_parity();
    cfg_write(4'b0101, 8'h01);
    send_and_check(8'hA7);
    cfg_write(4'b0101, 8'h02);
    send_and_check(8'h55);
    cfg_write(4'b0101, 8'h03);
    send_and_check(8'hA7);
    cfg_write(4'b0111, 8'hFF);
    send_and_check(8'h3C);
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    cfg_write(4'b0110, 8'h01);
    cfg_write(4'b0101, 8'h00);
    fork
      begin
        @(negedge clk);
        in_data  = 8'h00;
        in_valid = 1'b1;
        wait_ready(n1);
        if (n1 >= 0) push_exp(8'h00, n1);
        @(negedge clk);
        in_data = 8'hFF;
        wait_ready(n2);
        if (n2 >= 0) push_exp(8'hFF, n2);
        n_checks++;
        if (n1 < 0 || n2 !== n1 + 177)
          $display("FAIL back_to_back_accept: second accept at %0d, required %0d", n2, n1 + 177);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        recv_frame();
        recv_frame();
      end
    join
    cfg_write(4'b0110, 8'h00);
  endtask

  task automatic test_cfg_during_frame();
    int n, cw;
    fork
      send_byte(8'hC3, n);
      recv_frame();
      begin
        repeat (30) @(negedge clk);
        c_valid = 1'b1;
        c_addr  = 4'b0101;
        c_data  = 8'h01;
        n_checks++;
        if (c_ready !== 1'b0) $display("FAIL cfg_blocked: c_ready=%b mid-frame, required 0", c_ready);
        else n_pass++;
        wait_c_ready(cw);
        cfg_pm = 2'b01;
        n_checks++;
        if (cw !== n + 161) $display("FAIL cfg_landing: write taken at %0d, required %0d", cw, n + 161);
        else n_pass++;
        @(negedge clk);
        c_valid = 1'b0;
      end
    join
    send_and_check(8'hC3);
    fork
      begin
        @(negedge clk);
        c_valid  = 1'b1;
        c_addr   = 4'b0110;
        c_data   = 8'h01;
        in_valid = 1'b1;
        in_data  = 8'h81;
        wait_ready(n);
        cfg_s2 = 1'b1;
        if (n >= 0) push_exp(8'h81, n);
        @(negedge clk);
        c_valid  = 1'b0;
        in_valid = 1'b0;
      end
      recv_frame();
    join
  endtask

  task automatic test_reset_mid_frame();
    int   n;
    logic quiet;
    cfg_write(4'b0101, 8'h01);
    @(negedge clk);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    wait_ready(n);
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < n + 50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx, busy, tx_done, in_ready} !== 4'b1001)
      $display("FAIL reset_abort: tx/busy/done/in_ready=%b, required 1001", {tx, busy, tx_done, in_ready});
    else n_pass++;
    rst = 1'b0;
    cfg_pm = 2'b00;
    cfg_s2 = 1'b0;
    quiet = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx !== 1'b1) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL reset_quiet: tx_done or tx activity after abort, required none");
    else n_pass++;
    send_and_check(8'h96);
  endtask

  task automatic test_random_combos();
    for (int pm = 0; pm < 3; pm++) begin
      for (int s2 = 0; s2 < 2; s2++) begin
        cfg_write(4'b0101, 8'(pm));
        cfg_write(4'b0110, 8'(s2));
        repeat (2) send_and_check(8'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_parity();
    test_back_to_back();
    test_cfg_during_frame();
    test_reset_mid_frame();
    test_random_combos();
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
